// File: rtl/jtag_result_tx.sv
// TDO-side DR transmitter: buffers result words in a FIFO and shifts the head out as a framed DR.
// A head entry is popped only after its frame was shifted completely and then updated.
module jtag_result_tx #(
  parameter int RESULT_WIDTH = 16,
  parameter int DEPTH        = 4
) (
  input  logic                       tck,
  input  logic                       test_logic_reset,
  input  logic                       result_valid,
  input  logic [RESULT_WIDTH-1:0]    result_data,
  output logic                       result_ready,
  input  logic                       ir_is_user,
  input  logic                       capture_dr,
  input  logic                       shift_dr,
  input  logic                       update_dr,
  output logic                       tdo,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  // state    | meaning
  // IDLE     | no frame in progress
  // LOADED   | frame captured, nothing shifted yet
  // SHIFTING | part of the frame shifted out
  // DONE     | all FRAME_W bits shifted; update may pop
  localparam int FRAME_W = RESULT_WIDTH + 8;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, LOADED, SHIFTING, DONE} state_t;

  state_t                  state_q, state_d;
  logic [RESULT_WIDTH-1:0] mem_q [DEPTH];
  logic [RESULT_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [6:0]              seq_q, seq_d;
  logic [FRAME_W-1:0]      shift_reg_q, shift_reg_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic                    frame_valid_q, frame_valid_d;
  logic                    push, pop, non_empty;

  assign result_ready = (level_q != LVL_W'(DEPTH));
  assign level        = level_q;
  assign tdo          = shift_reg_q[0];
  assign non_empty    = (level_q != '0);
  assign push         = result_valid && result_ready;
  assign bit_cnt_inc  = bit_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    shift_reg_d   = shift_reg_q;
    bit_cnt_d     = bit_cnt_q;
    frame_valid_d = frame_valid_q;
    seq_d         = seq_q;
    pop           = 1'b0;

    if (ir_is_user) begin
      if (capture_dr) begin
        // Occupancy before this edge decides the frame, so a same-edge push is not seen.
        shift_reg_d   = {seq_q, non_empty, non_empty ? mem_q[rd_ptr_q] : {RESULT_WIDTH{1'b0}}};
        frame_valid_d = non_empty;
        bit_cnt_d     = '0;
        state_d       = LOADED;
      end else if (shift_dr) begin
        case (state_q)
          LOADED, SHIFTING: begin
            shift_reg_d = {1'b0, shift_reg_q[FRAME_W-1:1]};
            bit_cnt_d   = bit_cnt_inc;
            state_d     = (bit_cnt_inc == CNT_W'(FRAME_W)) ? DONE : SHIFTING;
          end
          DONE:    shift_reg_d = {1'b0, shift_reg_q[FRAME_W-1:1]};
          default: ;
        endcase
      end else if (update_dr) begin
        pop           = (state_q == DONE) && frame_valid_q && non_empty;
        frame_valid_d = 1'b0;
        state_d       = IDLE;
      end
    end

    if (pop) seq_d = seq_q + 7'd1;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = result_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      state_q       <= IDLE;
      shift_reg_q   <= '0;
      bit_cnt_q     <= '0;
      frame_valid_q <= 1'b0;
      seq_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      shift_reg_q   <= shift_reg_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_valid_q <= frame_valid_d;
      seq_q         <= seq_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: tb/tb_jtag_result_tx.sv
// Bench for jtag_result_tx: table of push/read operations against a FIFO model, with
// expected frames queued at capture and compared once the frame has been shifted out.
module tb_jtag_result_tx;

  logic        tck = 1'b0;
  logic        test_logic_reset = 1'b1;
  logic        result_valid = 1'b0;
  logic [15:0] result_data = '0;
  logic        result_ready;
  logic        ir_is_user = 1'b0;
  logic        capture_dr = 1'b0;
  logic        shift_dr = 1'b0;
  logic        update_dr = 1'b0;
  logic        tdo;
  logic [2:0]  level;

  int checks = 0;
  int failures = 0;

  logic [15:0] model_q[$];
  logic [6:0]  seq_m = '0;
  logic [23:0] exp_frames[$];

  typedef struct {
    int          kind;      // 0 = push, 1 = read
    logic [15:0] data;
    int          nshift;
    bit          upd_push;
    logic [15:0] upd_data;
    int          exp_level;
    bit          exp_ready;
  } vec_t;

  vec_t vecs[17];

  jtag_result_tx #(.RESULT_WIDTH(16), .DEPTH(4)) dut (
    .tck(tck), .test_logic_reset(test_logic_reset),
    .result_valid(result_valid), .result_data(result_data), .result_ready(result_ready),
    .ir_is_user(ir_is_user), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .tdo(tdo), .level(level)
  );

  always #5 tck = ~tck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge tck);
    #1;
  endtask

  task automatic do_push(input logic [15:0] d);
    check("push_ready", 32'(result_ready), 32'(model_q.size() < 4));
    result_valid = 1'b1;
    result_data  = d;
    if (model_q.size() < 4) model_q.push_back(d);
    cyc();
    result_valid = 1'b0;
  endtask

  task automatic do_read(input int nshift, input bit upd_push, input logic [15:0] upd_data);
    logic [23:0] got, efr, mask;
    logic        extra_bad;
    bit          ne;
    ne = (model_q.size() != 0);
    exp_frames.push_back({seq_m, ne, ne ? model_q[0] : 16'h0000});
    got = '0;
    extra_bad = 1'b0;
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    cyc();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < nshift; i++) begin
      if (i < 24) got[i] = tdo;
      else if (tdo !== 1'b0) extra_bad = 1'b1;
      cyc();
    end
    shift_dr = 1'b0;
    efr  = exp_frames.pop_front();
    mask = (nshift >= 24) ? 24'hFFFFFF : 24'((1 << nshift) - 1);
    check("frame", 32'(got & mask), 32'(efr & mask));
    if (nshift > 24) check("done_zeros", 32'(extra_bad), 32'd0);
    if (nshift >= 24) check("tdo_after_frame", 32'(tdo), 32'd0);
    update_dr = 1'b1;
    if (upd_push) begin
      result_valid = 1'b1;
      result_data  = upd_data;
    end
    cyc();
    update_dr = 1'b0;
    result_valid = 1'b0;
    if (upd_push && model_q.size() < 4) model_q.push_back(upd_data);
    if (nshift >= 24 && efr[16]) begin
      void'(model_q.pop_front());
      seq_m = seq_m + 7'd1;
    end
  endtask

  initial begin
    logic        any_one;
    logic [23:0] got;

    vecs[0]  = '{1, 16'h0000, 24, 1'b0, 16'h0000, 0, 1'b1};
    vecs[1]  = '{1, 16'h0000, 24, 1'b0, 16'h0000, 0, 1'b1};
    vecs[2]  = '{0, 16'hBEEF,  0, 1'b0, 16'h0000, 1, 1'b1};
    vecs[3]  = '{1, 16'h0000, 24, 1'b0, 16'h0000, 0, 1'b1};
    vecs[4]  = '{1, 16'h0000, 24, 1'b0, 16'h0000, 0, 1'b1};
    vecs[5]  = '{0, 16'h0001,  0, 1'b0, 16'h0000, 1, 1'b1};
    vecs[6]  = '{1, 16'h0000, 10, 1'b0, 16'h0000, 1, 1'b1};
    vecs[7]  = '{1, 16'h0000, 24, 1'b0, 16'h0000, 0, 1'b1};
    vecs[8]  = '{0, 16'h1111,  0, 1'b0, 16'h0000, 1, 1'b1};
    vecs[9]  = '{0, 16'h2222,  0, 1'b0, 16'h0000, 2, 1'b1};
    vecs[10] = '{0, 16'h3333,  0, 1'b0, 16'h0000, 3, 1'b1};
    vecs[11] = '{0, 16'h4444,  0, 1'b0, 16'h0000, 4, 1'b0};
    vecs[12] = '{1, 16'h0000, 24, 1'b0, 16'h0000, 3, 1'b1};
    vecs[13] = '{1, 16'h0000, 24, 1'b1, 16'h5555, 3, 1'b1};
    vecs[14] = '{1, 16'h0000, 24, 1'b0, 16'h0000, 2, 1'b1};
    vecs[15] = '{1, 16'h0000, 24, 1'b0, 16'h0000, 1, 1'b1};
    vecs[16] = '{1, 16'h0000, 28, 1'b0, 16'h0000, 0, 1'b1};

    #12;
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(result_ready), 32'd1);
    check("rst_tdo", 32'(tdo), 32'd0);
    @(negedge tck);
    test_logic_reset = 1'b0;
    cyc();

    for (int v = 0; v < 17; v++) begin
      if (vecs[v].kind == 0) do_push(vecs[v].data);
      else do_read(vecs[v].nshift, vecs[v].upd_push, vecs[v].upd_data);
      check($sformatf("vec%0d_level", v), 32'(level), 32'(vecs[v].exp_level));
      check($sformatf("vec%0d_ready", v), 32'(result_ready), 32'(vecs[v].exp_ready));
    end

    // TAP strobes with another IR selected must be ignored.
    do_push(16'hABCD);
    ir_is_user = 1'b0;
    any_one = 1'b0;
    capture_dr = 1'b1;
    cyc();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (tdo !== 1'b0) any_one = 1'b1;
      cyc();
    end
    shift_dr = 1'b0;
    update_dr = 1'b1;
    cyc();
    update_dr = 1'b0;
    check("ir0_tdo", 32'(any_one | tdo), 32'd0);
    check("ir0_level", 32'(level), 32'd1);

    // Re-capture after a partial shift restarts the frame; completed read then pops.
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    cyc();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    shift_dr = 1'b0;
    do_read(24, 1'b0, 16'h0000);
    check("recap_level", 32'(level), 32'd0);

    // Push on the capture edge into an empty FIFO is not part of that frame.
    capture_dr = 1'b1;
    result_valid = 1'b1;
    result_data = 16'h7777;
    cyc();
    capture_dr = 1'b0;
    result_valid = 1'b0;
    got = '0;
    shift_dr = 1'b1;
    for (int i = 0; i < 24; i++) begin
      got[i] = tdo;
      cyc();
    end
    shift_dr = 1'b0;
    check("cap_push_frame", 32'(got), 32'({seq_m, 1'b0, 16'h0000}));
    update_dr = 1'b1;
    cyc();
    update_dr = 1'b0;
    model_q.push_back(16'h7777);
    check("cap_push_level", 32'(level), 32'd1);
    do_read(24, 1'b0, 16'h0000);

    // Reset mid-shift clears immediately, flushes the FIFO and the sequence counter.
    do_push(16'hF00F);
    capture_dr = 1'b1;
    cyc();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    for (int i = 0; i < 12; i++) cyc();
    shift_dr = 1'b0;
    check("pre_rst_tdo", 32'(tdo), 32'd1);
    #2;
    test_logic_reset = 1'b1;
    #1;
    check("mid_rst_tdo", 32'(tdo), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_ready", 32'(result_ready), 32'd1);
    @(negedge tck);
    test_logic_reset = 1'b0;
    model_q.delete();
    seq_m = '0;
    cyc();
    do_push(16'h1234);
    do_read(24, 1'b0, 16'h0000);
    check("post_rst_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
